// File: rtl/memarb_if.sv
// Bus bundle for memarb: fetch port, MEM-stage data port and the shared memory port.
// The arbiter takes the slave side; requesters and the memory take the master side.
interface memarb_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

// File: rtl/memarb.sv
// Single-port memory arbiter: data port has priority, a starvation counter guarantees
// fetch progress, reads wait MEM_LAT cycles and return data to their owner.
module memarb #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic     clk,
    input  logic     rst,
    memarb_if.slave  bus,
    output logic     busy
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [2:0]      lat_cnt;
    logic            own_if;
    logic            kill_flag;
    logic            gnt_if, gnt_dm, rd_grant, rd_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Grants are gated by rst so nothing reaches the memory while reset is held.
    always_comb begin
        gnt_if         = 1'b0;
        gnt_dm         = 1'b0;
        state_nxt      = state;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wstrb  = '0;
        rd_done        = (state == RD_WAIT) && (lat_cnt == 3'd1);
        if (state == IDLE && rst) begin
            if (bus.if_req && (starve_cnt == SW'(STARVE_MAX) || !bus.dm_req)) begin
                gnt_if       = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.if_addr;
            end else if (bus.dm_req) begin
                gnt_dm        = 1'b1;
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.dm_we;
                bus.mem_addr  = bus.dm_addr;
                bus.mem_wdata = bus.dm_wdata;
                bus.mem_wstrb = bus.dm_we ? bus.dm_wstrb : 4'b0000;
            end
        end
        rd_grant = gnt_if || (gnt_dm && !bus.dm_we);
        if (rd_grant)     state_nxt = RD_WAIT;
        else if (rd_done) state_nxt = IDLE;
    end

    assign bus.if_gnt = gnt_if;
    assign bus.dm_gnt = gnt_dm;
    assign busy       = (state == RD_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt    <= '0;
            lat_cnt       <= '0;
            own_if        <= 1'b0;
            kill_flag     <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.dm_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            // A kill raised in the capture cycle itself must still suppress the pulse.
            bus.if_rvalid <= rd_done && own_if && !(kill_flag || bus.if_kill);
            bus.dm_rvalid <= rd_done && !own_if;
            if (rd_done) begin
                if (own_if) bus.if_rdata <= bus.mem_rdata;
                else        bus.dm_rdata <= bus.mem_rdata;
            end

            if (rd_grant) begin
                lat_cnt   <= 3'(MEM_LAT);
                own_if    <= gnt_if;
                kill_flag <= gnt_if && bus.if_kill;
            end else if (state == RD_WAIT) begin
                lat_cnt   <= lat_cnt - 3'd1;
                kill_flag <= !rd_done && (kill_flag || (own_if && bus.if_kill));
            end

            if (gnt_if)
                starve_cnt <= '0;
            else if (gnt_dm && bus.if_req && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: doc/memarb.md
# memarb

Single-port memory arbiter for the r200 pipeline. It shares one unified instruction/data memory between the instruction-fetch port and the MEM-stage data port. It grants one access at a time, sequences the fixed read latency, and returns read data to the owning requester. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
- MEM_LAT, 2, memory read latency in cycles (legal range 1..7)
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins the next arbitration (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  32  fetch word address
- if_kill  in  1  discard the outstanding fetch response (PC redirect)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid (one-cycle pulse)
- if_rdata  out  32  fetch read data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  32  data address
- dm_wdata  in  32  write data
- dm_wstrb  in  4  byte enables for writes
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  data read valid (one-cycle pulse)
- dm_rdata  out  32  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables (0000 on reads)
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  arbiter not in IDLE

## Operation
- FSM states: IDLE and RD_WAIT. Writes complete in the grant cycle and never leave IDLE.
- Arbitration happens in IDLE only:
  - dm_req wins over if_req.
  - Exception: if starve_cnt == STARVE_MAX and if_req=1, fetch wins.
- Grant cycle T:
  - The selected gnt is asserted combinationally.
  - mem_en=1; mem_addr, mem_we, mem_wdata and mem_wstrb are muxed from the winner.
  - A fetch grant forces mem_we=0 and mem_wstrb=0.
- Read grant: go to RD_WAIT and record the owner (IF or DM). Latency counter is loaded with MEM_LAT.
- RD_WAIT:
  - Counter decrements each cycle.
  - At count 1 (cycle T+MEM_LAT), mem_rdata is captured into the owner's rdata register and the owner's rvalid is set for the next cycle.
  - The FSM returns to IDLE in that same transition.
- Write grant: stays in IDLE, so a new grant is allowed at T+1. No rvalid is produced.
- Starvation counter, width ceil(log2(STARVE_MAX+1)):
  - +1 on each DM grant while if_req=1.
  - Cleared on each IF grant.
  - Saturates at STARVE_MAX.
- if_kill:
  - Asserted in cycle T of a fetch grant, or in any RD_WAIT cycle with owner IF: sets a kill flag.
  - When the kill flag is set, the captured response produces no if_rvalid pulse.
  - if_kill with no fetch outstanding has no effect.
  - if_kill never affects DM responses.
- if_rdata and dm_rdata hold their last captured value between responses.
- Requester rules: req/addr must stay stable until gnt. Deasserting req before gnt withdraws the request.

## Timing
- Reset (rst=0), asynchronous:
  - state=IDLE, starve_cnt=0, kill flag=0.
  - if_rvalid=dm_rvalid=0, if_rdata=dm_rdata=0, busy=0.
  - An in-flight read is dropped and no rvalid is produced after reset release.
- gnt, mem_en, mem_we, mem_addr, mem_wdata and mem_wstrb are combinational, valid only in IDLE. All are 0 outside a grant cycle.
- Read round-trip: gnt at T, rvalid at T+MEM_LAT+1.
- Back-to-back grants:
  - Next grant possible at T+MEM_LAT+1, the same cycle as the previous rvalid.
  - Read throughput: one read per MEM_LAT+1 cycles.
  - Write throughput: one write per cycle.
- busy=1 exactly in RD_WAIT cycles.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_MAX: DM granted and starve_cnt increments.
- MEM_LAT=1: RD_WAIT lasts exactly one cycle.

## Test plan
- Reset and idle:
  - Stimulus: rst low then released, no requests.
  - Expect: all outputs 0, busy=0, mem_en never asserted.
- Single fetch, MEM_LAT=2:
  - Stimulus: if_req=1 with addr 0x100 at cycle 5; memory model returns 0xDEADBEEF at cycle 7.
  - Expect: if_gnt and mem_en at cycle 5; if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 8 only; busy high in cycles 6–7.
- Priority and starvation, STARVE_MAX=4:
  - Stimulus: if_req and dm_req (writes) held continuously.
  - Expect: DM granted 4 consecutive cycles, then IF granted on the 5th arbitration, then DM resumes with starve_cnt=0.
- Write then read:
  - Stimulus: DM write 0xA5A5A5A5 to 0x40 with wstrb=0011, then DM read of 0x40 on the next cycle.
  - Expect: grants in consecutive cycles, mem_wstrb=0011 on the write cycle, dm_rvalid MEM_LAT+1 cycles after the read grant.
- Kill:
  - Stimulus: fetch granted at cycle T, if_kill pulsed at T+1.
  - Expect: no if_rvalid at T+3; a DM request pending since T+1 is granted at T+3.
- Reset mid-read:
  - Stimulus: rst low at T+1 after a DM read grant at T, released at T+2.
  - Expect: outputs 0 immediately, no dm_rvalid ever for that read, next request granted normally.
